button_event_decoder: RTL and testbench

//  Consumes the clean level from a debounced button and turns it into single-cycle

---
 rtl/button_pkg.sv | 17 +
 rtl/button_event_decoder_if.sv | 25 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/button_event_decoder.sv | 137 +++++++++++++
 tb/tb_button_event_decoder.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/button_pkg.sv
// Shared types and constants for button event decoding.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  localparam int LONG_CYCLES_DEF   = 100_000_000;
  localparam int REPEAT_CYCLES_DEF = 20_000_000;

  // Small thresholds so simulations stay short
  localparam int LONG_SIM   = 8;
  localparam int REPEAT_SIM = 4;

endpackage

// File: rtl/button_event_decoder_if.sv
// Button level in, decoded single-cycle events and press counter out.
interface button_event_decoder_if;

  logic       db_in;
  logic       press_pulse;
  logic       release_pulse;
  logic       click_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       held;
  logic [7:0] press_count;

  modport master (
    output db_in,
    input  press_pulse, release_pulse, click_pulse, long_pulse,
           repeat_pulse, held, press_count
  );

  modport slave (
    input  db_in,
    output press_pulse, release_pulse, click_pulse, long_pulse,
           repeat_pulse, held, press_count
  );

endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-low clear.
module sync_2ff (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a resynchronised debounced button level into press/release/click/long/repeat events.
// Optional auto-repeat while long-held is enabled by defining AUTO_REPEAT_EN.
module button_event_decoder
  import button_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CNT_W         = 27
) (
  input  logic                  clock,
  input  logic                  reset_n,
  button_event_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 1 || CNT_W < 1 || CNT_W > 62 ||
      longint'(LONG_CYCLES - 1) >= (64'sd1 <<< CNT_W) ||
      longint'(REPEAT_CYCLES - 1) >= (64'sd1 <<< CNT_W)) begin : g_param_check
    $error("button_event_decoder: invalid LONG_CYCLES/REPEAT_CYCLES/CNT_W");
  end

  logic             s2;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       count_q, count_nxt;
  logic             press_q, release_q, click_q, long_q, held_q;
  logic             press_nxt, release_nxt, click_nxt, long_nxt, repeat_nxt;

  sync_2ff u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (bus.db_in),
    .q       (s2)
  );

  // Release is checked first in every held state so it wins any race with a threshold
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    count_nxt   = count_q;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    click_nxt   = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (s2) begin
          state_nxt = PRESSED;
          press_nxt = 1'b1;
          cnt_nxt   = '0;
          count_nxt = count_q + 8'd1;
        end
      end
      PRESSED: begin
        if (!s2) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
          click_nxt   = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_nxt = LONG_HELD;
          long_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      LONG_HELD: begin
        if (!s2) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end
`ifdef AUTO_REPEAT_EN
        else if (cnt == CNT_W'(REPEAT_CYCLES - 1)) begin
          repeat_nxt = 1'b1;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      count_q   <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      count_q   <= count_nxt;
      press_q   <= press_nxt;
      release_q <= release_nxt;
      click_q   <= click_nxt;
      long_q    <= long_nxt;
      held_q    <= (state_nxt != IDLE);
    end
  end

`ifdef AUTO_REPEAT_EN
  logic repeat_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= repeat_nxt;
    end
  end

  assign bus.repeat_pulse = repeat_q;
`else
  logic unused_repeat;
  assign unused_repeat    = repeat_nxt;
  assign bus.repeat_pulse = 1'b0;
`endif

  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.click_pulse   = click_q;
  assign bus.long_pulse    = long_q;
  assign bus.held          = held_q;
  assign bus.press_count   = count_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder with LONG_CYCLES=8, REPEAT_CYCLES=4.
// Expectations follow AUTO_REPEAT_EN the same way the design does.
module tb_button_event_decoder;
  import button_pkg::*;

  localparam logic [4:0] EV_PRESS   = 5'b10000;
  localparam logic [4:0] EV_RELEASE = 5'b01000;
  localparam logic [4:0] EV_CLICK   = 5'b00100;
  localparam logic [4:0] EV_LONG    = 5'b00010;
  localparam logic [4:0] EV_REPEAT  = 5'b00001;

  typedef struct {
    int         at;
    logic [4:0] pulses;
    logic [7:0] count;
    logic       held;
  } ev_t;

  logic clock;
  logic reset_n;
  int   cyc;
  int   tests;
  int   fails;
  int   model_count;
  int   press_seen;
  ev_t  sb[$];

  button_event_decoder_if bus ();

  button_event_decoder #(
    .LONG_CYCLES   (LONG_SIM),
    .REPEAT_CYCLES (REPEAT_SIM),
    .CNT_W         (27)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [4:0] pulse_vec();
    return {bus.press_pulse, bus.release_pulse, bus.click_pulse,
            bus.long_pulse, bus.repeat_pulse};
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  task automatic push_ev(input int at, input logic [4:0] pulses, input logic held);
    ev_t e;
    e.at     = at;
    e.pulses = pulses;
    e.count  = 8'(model_count);
    e.held   = held;
    sb.push_back(e);
  endtask

  // Monitor: any pulse seen must match the head of the scoreboard
  always @(negedge clock) begin
    if (reset_n && pulse_vec() != 5'b0) begin
      if (bus.press_pulse) press_seen++;
      if (sb.size() == 0) begin
        check_output("unexpected_event", {27'd0, pulse_vec()}, 32'd0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check_output("event_cycle", cyc, e.at);
        check_output("event_pulses", {27'd0, pulse_vec()}, {27'd0, e.pulses});
        check_output("event_count", {24'd0, bus.press_count}, {24'd0, e.count});
        check_output("event_held", {31'd0, bus.held}, {31'd0, e.held});
      end
    end
  end

  // One press held for len cycles, then gap low cycles
  task automatic apply_stimulus(input int len, input int gap);
    int p;
    @(negedge clock);
    bus.db_in = 1'b1;
    p = cyc + 1 + 2;
    model_count++;
    push_ev(p, EV_PRESS, 1'b1);
    if (len > LONG_SIM) begin
      push_ev(p + LONG_SIM, EV_LONG, 1'b1);
`ifdef AUTO_REPEAT_EN
      for (int t = p + LONG_SIM + REPEAT_SIM; t < p + len; t += REPEAT_SIM)
        push_ev(t, EV_REPEAT, 1'b1);
`endif
      push_ev(p + len, EV_RELEASE, 1'b0);
    end else begin
      push_ev(p + len, EV_RELEASE | EV_CLICK, 1'b0);
    end
    repeat (len) @(negedge clock);
    bus.db_in = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  initial begin
    int p;
    cyc         = 0;
    tests       = 0;
    fails       = 0;
    model_count = 0;
    press_seen  = 0;
    reset_n     = 1'b0;
    bus.db_in   = 1'b1;

    // Reset with button already down
    repeat (5) @(negedge clock);
    check_output("reset_pulses", {27'd0, pulse_vec()}, 32'd0);
    check_output("reset_held", {31'd0, bus.held}, 32'd0);
    check_output("reset_count", {24'd0, bus.press_count}, 32'd0);

    reset_n = 1'b1;
    p = cyc + 1 + 2;
    model_count = 1;
    push_ev(p, EV_PRESS, 1'b1);
    repeat (5) @(negedge clock);
    check_output("hold_held", {31'd0, bus.held}, 32'd1);
    check_output("hold_count", {24'd0, bus.press_count}, 32'd1);

    // Asynchronous reset mid-hold
    #2 reset_n = 1'b0;
    #1;
    check_output("async_reset_held", {31'd0, bus.held}, 32'd0);
    check_output("async_reset_count", {24'd0, bus.press_count}, 32'd0);
    check_output("async_reset_pulses", {27'd0, pulse_vec()}, 32'd0);
    model_count = 0;
    bus.db_in   = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // Short click
    apply_stimulus(5, 4);
    check_output("click_count", {24'd0, bus.press_count}, 32'd1);

    // Long hold, 30 cycles
    apply_stimulus(30, 0);
    check_output("long_held_before_release", {31'd0, bus.held}, 32'd1);
    repeat (4) @(negedge clock);
    check_output("long_held_after_release", {31'd0, bus.held}, 32'd0);

    // Release on the threshold edge
    apply_stimulus(LONG_SIM, 4);
    check_output("race_held", {31'd0, bus.held}, 32'd0);
    check_output("race_count", {24'd0, bus.press_count}, 32'd3);

    // Counter wrap over 257 presses
    reset_n = 1'b0;
    @(negedge clock);
    reset_n     = 1'b1;
    model_count = 0;
    press_seen  = 0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 257; i++) apply_stimulus(2, 3);
    repeat (4) @(negedge clock);
    check_output("wrap_count", {24'd0, bus.press_count}, 32'd1);
    check_output("wrap_press_events", press_seen, 32'd257);

    repeat (4) @(negedge clock);
    check_output("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
